// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op codes, FSM states
// and small decode helpers used by the controller and its arithmetic core.
package mdu_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam int CNT_W = 4;

  function automatic logic isMulOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-side handshake of the MDU: E-stage request, D-stage use flag,
// and the busy/stall/HI/LO responses.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (output start, op, rs_val, rt_val, md_use,
                  input  busy, stall, hi_out, lo_out);
  modport slave  (input  start, op, rs_val, rt_val, md_use,
                  output busy, stall, hi_out, lo_out);
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide core working on the latched operands.
// Division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        isSigned,
  output logic [63:0] product,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        divZero
);
  logic signed [63:0] sa, sb;
  logic        negA, negB;
  logic [31:0] magA, magB, divisor, uq, ur;

  assign sa = {{32{a[31]}}, a};
  assign sb = {{32{b[31]}}, b};
  assign product = isSigned ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});

  assign negA    = isSigned & a[31];
  assign negB    = isSigned & b[31];
  assign magA    = negA ? (~a + 32'd1) : a;
  assign magB    = negB ? (~b + 32'd1) : b;
  assign divZero = (b == 32'd0);
  // Substitute 1 so a zero divisor never reaches the divider; the result is discarded.
  assign divisor = divZero ? 32'd1 : magB;
  assign uq      = magA / divisor;
  assign ur      = magA % divisor;
  assign quot    = (negA ^ negB) ? (~uq + 32'd1) : uq;
  assign rem     = negA ? (~ur + 32'd1) : ur;
endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: FSM, busy counter, operand latches and HI/LO registers.
// Results land in HI/LO on the edge that drops busy.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  mdu_ctrl_if.slave    bus
);
  logic [1:0]       stateReg;
  logic [CNT_W-1:0] cntReg;
  logic [31:0]      rsReg, rtReg, hiReg, loReg;
  logic             signedReg;

  logic [63:0] product;
  logic [31:0] quot, rem;
  logic        divZero;

  mdu_arith uArith (
    .a        (rsReg),
    .b        (rtReg),
    .isSigned (signedReg),
    .product  (product),
    .quot     (quot),
    .rem      (rem),
    .divZero  (divZero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg  <= ST_IDLE;
      cntReg    <= '0;
      rsReg     <= '0;
      rtReg     <= '0;
      signedReg <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (bus.start) begin
            if (isMulOp(bus.op) || isDivOp(bus.op)) begin
              rsReg     <= bus.rs_val;
              rtReg     <= bus.rt_val;
              signedReg <= isSignedOp(bus.op);
            end
            if (isMulOp(bus.op)) begin
              cntReg   <= CNT_W'(MULT_CYCLES);
              stateReg <= ST_MUL;
            end else if (isDivOp(bus.op)) begin
              cntReg   <= CNT_W'(DIV_CYCLES);
              stateReg <= ST_DIV;
            end else if (bus.op == OP_MTHI) begin
              hiReg <= bus.rs_val;
            end else if (bus.op == OP_MTLO) begin
              loReg <= bus.rs_val;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          cntReg <= cntReg - CNT_W'(1);
          if (cntReg == CNT_W'(1)) begin
            stateReg <= ST_IDLE;
            if (stateReg == ST_MUL) begin
              hiReg <= product[63:32];
              loReg <= product[31:0];
            end else if (!divZero) begin
              hiReg <= rem;
              loReg <= quot;
            end
          end
        end
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (stateReg != ST_IDLE);
  assign bus.stall  = bus.md_use &
                      (bus.busy | (bus.start & (isMulOp(bus.op) | isDivOp(bus.op))));
  assign bus.hi_out = hiReg;
  assign bus.lo_out = loReg;
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU, in cycles, range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU, in cycles, range 1..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  E-stage MDU instruction is valid this cycle.
REQ-007 op  in  3  MDU operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO; any other code is a no-op.
REQ-008 rs_val  in  32  forwarded rs operand.
REQ-009 rt_val  in  32  forwarded rt operand.
REQ-010 md_use  in  1  D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-011 busy  out  1  multi-cycle operation in progress.
REQ-012 stall  out  1  stall request to the hazard unit.
REQ-013 hi_out  out  32  HI register contents.
REQ-014 lo_out  out  32  LO register contents.

Function
REQ-015 FSM states: IDLE, MUL, DIV; a 4-bit down-counter cnt sequences MUL and DIV.
REQ-016 In IDLE, start with op MULT/MULTU SHALL latch the operands, load cnt=MULT_CYCLES and enter MUL.
REQ-017 In IDLE, start with op DIV/DIVU SHALL latch the operands, load cnt=DIV_CYCLES and enter DIV.
REQ-018 In MUL/DIV, cnt SHALL decrement each edge; on the edge where cnt==1 the block SHALL write HI/LO and return to IDLE.
REQ-019 busy SHALL be 1 exactly when the state is not IDLE: N cycles after the start edge, where N is MULT_CYCLES or DIV_CYCLES.
REQ-020 The new HI/LO values SHALL be visible on the hi_out/lo_out outputs on the same edge on which busy falls.
REQ-021 MULT: {HI,LO} = signed 32x32 to 64-bit product; MULTU: unsigned product.
REQ-022 DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; DIVU: unsigned quotient and remainder.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-024 Divide by zero (DIV or DIVU, rt_val==0) SHALL take the full DIV_CYCLES, then leave HI/LO unchanged.
REQ-025 MTHI/MTLO in IDLE SHALL write rs_val to HI/LO at the next edge, with no busy cycle.
REQ-026 start while busy (any op) SHALL be ignored; the hazard unit guarantees it does not occur, and the bench checks it is harmless.
REQ-027 start with an undefined op code SHALL be ignored.
REQ-028 The operands used by an operation SHALL be the operands latched at the start edge; later changes to rs_val/rt_val SHALL NOT affect the result.
REQ-029 stall = md_use & (busy | (start & op is MULT/MULTU/DIV/DIVU)), combinational.
REQ-030 hi_out/lo_out SHALL come directly from registers, with no combinational path from the inputs.

Reset
REQ-031 reset_n low SHALL asynchronously force state IDLE, cnt=0, busy=0, HI=0, LO=0 and clear the latched operands.
REQ-032 Reset in the middle of an operation SHALL abort it with no HI/LO write; stall SHALL drop to md_use & start-dependent terms only.
REQ-033 After reset_n rises, the first start SHALL be accepted at the next edge.

Structure
REQ-034 The op encodings and the FSM state encodings SHALL live in the shared CPU definitions header/package, together with the existing control constants.
REQ-035 A single combinational sub-module, mdu_arith, SHALL compute the 64-bit product and the quotient/remainder from the latched operands, op and signedness.
REQ-036 mdu_ctrl SHALL contain only the FSM, the counter, the operand latches and the HI/LO registers.

Verification
REQ-037 MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-038 MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-039 DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> HI/LO unchanged after 10 cycles.
REQ-040 Issue MULT, then md_use=1 on the next 5 cycles -> stall=1 on all 5; a start of DIV during busy is ignored, and the MULT result is correct.
REQ-041 MTHI rs=0x12345678 in IDLE -> hi_out=0x12345678 next cycle, busy never asserted.
REQ-042 Pulse reset_n low 3 cycles after a DIV start -> busy, hi_out and lo_out are 0 immediately, and no later write occurs.
